keyboard_ctrl: RTL and testbench

PS/2 keyboard front-end controller: samples the raw PS/2 clock/data lines in the system clock domain and frames 11-bit packets with parity, stop and timeout checks. It sequences the scan-code protocol (E0 extended prefix, F0 break prefix) into complete key events and buffers them in a small FIFO with a valid/ready interface. It sits between the PS/2 pins and game/UI logic.

---
 rtl/keyboard_pkg.sv | 34 +++
 rtl/keyboard_ctrl_ps2_frame_rx.sv | 91 +++++++++
 rtl/keyboard_ctrl.sv | 146 ++++++++++++++
 tb/tb_keyboard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front-end.
package keyboard_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } kb_state_e;

  localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] KB_BAT_OK     = 8'hAA;
  localparam logic [7:0] KB_ACK        = 8'hFA;
  localparam logic [7:0] KB_ECHO       = 8'hEE;
  localparam logic [7:0] KB_ERR_00     = 8'h00;
  localparam logic [7:0] KB_ERR_FF     = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kb_evt_t;

  // Keyboard status replies that carry no key information when seen between events
  function automatic logic is_status_code(input logic [7:0] b);
    return (b == KB_BAT_OK) || (b == KB_ACK) || (b == KB_ECHO);
  endfunction

  function automatic logic is_error_code(input logic [7:0] b);
    return (b == KB_ERR_00) || (b == KB_ERR_FF);
  endfunction

endpackage

// File: rtl/keyboard_ctrl_ps2_frame_rx.sv
// PS/2 line synchronizers, falling-edge detect and 11-bit frame receiver
// with parity, stop-bit and inactivity-timeout checking.
module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_dly;
  logic            fe;
  logic [3:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par;
  logic [TO_W-1:0] to_cnt;
  logic            din;

  assign din       = data_sync[1];
  assign byte_data = shreg;

  // Two-flop synchronizers; fe is registered so it lands 3 cycles after the pin edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_dly   <= 1'b1;
      fe        <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      clk_dly   <= clk_sync[1];
      fe        <= clk_dly & ~clk_sync[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_idx    <= 4'd0;
      shreg      <= 8'h00;
      par        <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        to_cnt <= '0;
        if (bit_idx == 4'd0) begin
          // A high level here is line noise, not a start bit
          if (!din) begin
            bit_idx <= 4'd1;
            par     <= 1'b0;
          end
        end else if (bit_idx == 4'd9) begin
          par     <= par ^ din;
          bit_idx <= 4'd10;
        end else if (bit_idx == 4'd10) begin
          if (par && din) byte_valid <= 1'b1;
          else            frame_err  <= 1'b1;
          bit_idx <= 4'd0;
        end else begin
          shreg   <= {din, shreg[7:1]};
          par     <= par ^ din;
          bit_idx <= bit_idx + 4'd1;
        end
      end else if (bit_idx != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          bit_idx   <= 4'd0;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keyboard_ctrl.sv
// PS/2 keyboard front-end: frames bytes, decodes E0/F0 prefixes into key
// events and buffers them in a show-ahead FIFO with valid/ready handshake.
module keyboard_ctrl
  import keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_evt_valid,
  input  logic       i_evt_ready,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_release,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign o_frame_err = frame_err;

  kb_state_e state_q, state_d;
  logic      emit;
  kb_evt_t   emit_evt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Prefix sequencing; every non-prefix byte closes the event with accumulated flags
  always_comb begin
    state_d       = state_q;
    emit          = 1'b0;
    emit_evt.ext  = 1'b0;
    emit_evt.rel  = 1'b0;
    emit_evt.code = byte_data;
    if (frame_err) begin
      state_d = S_IDLE;
    end else if (byte_valid) begin
      if (is_error_code(byte_data)) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_data == KB_PREFIX_EXT)      state_d = S_EXT;
            else if (byte_data == KB_PREFIX_BRK) state_d = S_BRK;
            else if (!is_status_code(byte_data)) emit    = 1'b1;
          end
          S_EXT: begin
            if (byte_data == KB_PREFIX_BRK) state_d = S_EXT_BRK;
            else if (byte_data != KB_PREFIX_EXT) begin
              emit         = 1'b1;
              emit_evt.ext = 1'b1;
              state_d      = S_IDLE;
            end
          end
          S_BRK: begin
            if (byte_data == KB_PREFIX_EXT) state_d = S_EXT;
            else if (byte_data != KB_PREFIX_BRK) begin
              emit         = 1'b1;
              emit_evt.rel = 1'b1;
              state_d      = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if (byte_data == KB_PREFIX_EXT) state_d = S_EXT;
            else if (byte_data != KB_PREFIX_BRK) begin
              emit         = 1'b1;
              emit_evt.ext = 1'b1;
              emit_evt.rel = 1'b1;
              state_d      = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  kb_evt_t        mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic           overflow_q;
  kb_evt_t        head;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = o_evt_valid && i_evt_ready;
  assign push_ok = emit && (!full || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= emit && full && !pop;
      if (push_ok) begin
        mem[wr_ptr] <= emit_evt;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is read straight from storage so a push is only visible a cycle later
  assign head          = mem[rd_ptr];
  assign o_evt_valid   = (count != '0);
  assign o_evt_code    = head.code;
  assign o_evt_ext     = head.ext;
  assign o_evt_release = head.rel;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Directed bench for keyboard_ctrl: drives PS/2 frames and checks decoded events.
module tb_keyboard_ctrl;

  localparam int unsigned TO    = 256;
  localparam int unsigned DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_data = 1'b1;
  logic       i_evt_ready = 1'b1;
  logic       o_evt_valid;
  logic [7:0] o_evt_code;
  logic       o_evt_ext;
  logic       o_evt_release;
  logic       o_frame_err;
  logic       o_overflow;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;
  int err_long = 0;
  int ov_pulses = 0;
  int ov_long = 0;
  logic err_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [9:0] popq [$];

  keyboard_ctrl #(
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ps2_clk     (i_ps2_clk),
    .i_ps2_data    (i_ps2_data),
    .o_evt_valid   (o_evt_valid),
    .i_evt_ready   (i_evt_ready),
    .o_evt_code    (o_evt_code),
    .o_evt_ext     (o_evt_ext),
    .o_evt_release (o_evt_release),
    .o_frame_err   (o_frame_err),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters and popped-event log
  always @(posedge i_clk) begin
    if (o_frame_err) begin
      if (err_prev) err_long <= err_long + 1;
      else          err_pulses <= err_pulses + 1;
    end
    if (o_overflow) begin
      if (ov_prev) ov_long <= ov_long + 1;
      else         ov_pulses <= ov_pulses + 1;
    end
    err_prev <= o_frame_err;
    ov_prev  <= o_overflow;
    if (o_evt_valid && i_evt_ready) popq.push_back({o_evt_ext, o_evt_release, o_evt_code});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input logic [9:0] exp);
    logic [31:0] got;
    got = (popq.size() > 0) ? 32'(popq.pop_front()) : 32'hDEAD;
    check(tag, got, 32'(exp));
  endtask

  // Device-side PS/2 timing: data set while clock high, 12 system cycles per bit
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge i_clk);
      i_ps2_data = bits[i];
      repeat (3) @(negedge i_clk);
      i_ps2_clk = 1'b0;
      repeat (6) @(negedge i_clk);
      i_ps2_clk = 1'b1;
      repeat (3) @(negedge i_clk);
    end
    i_ps2_data = 1'b1;
    repeat (20) @(negedge i_clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  initial begin
    logic bv_seen;
    #2 i_rst_n = 1'b0;
    #1;
    check("reset_outputs",
          32'({o_evt_valid, o_evt_ext, o_evt_release, o_evt_code, o_frame_err, o_overflow}), 32'h0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("idle_valid", 32'(o_evt_valid), 32'h0);

    send(8'h1C);
    expect_evt("make_1c", {1'b0, 1'b0, 8'h1C});
    check("make_no_err", 32'(err_pulses), 32'd0);

    send(8'hF0); send(8'h1C);
    expect_evt("break_1c", {1'b0, 1'b1, 8'h1C});
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt("ext_break_75", {1'b1, 1'b1, 8'h75});
    send(8'hE0); send(8'h75);
    expect_evt("ext_make_75", {1'b1, 1'b0, 8'h75});
    send(8'hAA);
    check("status_dropped", 32'(popq.size()), 32'd0);

    send(8'hE0);
    send_frame(8'h1C, 1'b1, 11);
    check("parity_err_pulse", 32'(err_pulses), 32'd1);
    check("parity_err_width", 32'(err_long), 32'd0);
    check("parity_no_event", 32'(popq.size()), 32'd0);
    send(8'h1C);
    expect_evt("after_err_idle", {1'b0, 1'b0, 8'h1C});
    send(8'hF0); send(8'h1C);
    expect_evt("after_err_break", {1'b0, 1'b1, 8'h1C});

    send_frame(8'h1C, 1'b0, 5);
    repeat (TO - 60) @(negedge i_clk);
    check("timeout_not_early", 32'(err_pulses), 32'd1);
    repeat (100) @(negedge i_clk);
    check("timeout_pulse", 32'(err_pulses), 32'd2);
    check("timeout_width", 32'(err_long), 32'd0);
    send(8'h1C);
    expect_evt("after_timeout", {1'b0, 1'b0, 8'h1C});

    i_evt_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(8'(k));
    check("ovf_pulse", 32'(ov_pulses), 32'd1);
    check("ovf_width", 32'(ov_long), 32'd0);
    check("full_head", 32'({o_evt_valid, o_evt_code}), 32'h101);
    i_evt_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    for (int k = 1; k <= 4; k++) expect_evt($sformatf("drain_%0d", k), {2'b00, 8'(k)});
    check("drain_empty", 32'({o_evt_valid, 8'(popq.size())}), 32'h0);

    i_evt_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(8'(8'h10 + k));
    bv_seen = 1'b0;
    fork
      send(8'h15);
      begin
        for (int c = 0; c < 400 && !bv_seen; c++) begin
          @(negedge i_clk);
          if (dut.byte_valid) bv_seen = 1'b1;
        end
        if (bv_seen) begin
          i_evt_ready = 1'b1;
          @(negedge i_clk);
          i_evt_ready = 1'b0;
        end
      end
    join
    check("fullpop_bv_seen", 32'(bv_seen), 32'd1);
    check("fullpop_no_ovf", 32'(ov_pulses), 32'd1);
    expect_evt("fullpop_pop", {2'b00, 8'h11});
    check("fullpop_head", 32'({o_evt_valid, o_evt_code}), 32'h112);
    i_evt_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    for (int k = 2; k <= 5; k++) expect_evt($sformatf("fullpop_drain_%0d", k), {2'b00, 8'(8'h10 + k)});
    check("fullpop_empty", 32'(popq.size()), 32'd0);

    i_evt_ready = 1'b0;
    send(8'h21);
    check("pre_reset_valid", 32'(o_evt_valid), 32'd1);
    send_frame(8'h33, 1'b0, 4);
    #3 i_rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({o_evt_valid, o_evt_ext, o_evt_release, o_evt_code, o_frame_err, o_overflow}), 32'h0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    i_evt_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("post_reset_empty", 32'({o_evt_valid, 8'(popq.size())}), 32'h0);
    send(8'h1C);
    expect_evt("post_reset_make", {1'b0, 1'b0, 8'h1C});
    check("final_err_count", 32'(err_pulses), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
